// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external combinational ALU. Each
// operation is accepted, executed, and then held as a response.
// Latency: 2 cycles from the accept edge to rspN_valid. Peak rate: one
// operation every 3 cycles.
// Backpressure: the held response stays until the owner raises rspN_ready.
// No new request is accepted until the block is back in IDLE.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   reqN_valid/_a/_b/_op/_ready     request side, valid/ready per requester
//   alu_a, alu_b, alu_control       registered operands/op to shared ALU
//   alu_result, alu_flags           combinational ALU return path
//   rspN_valid/_ready               response handshake per requester
//   rsp_result, rsp_flags           captured ALU outputs ({C,L,F,Z,N})
//   busy                            high whenever not IDLE
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [4:0]       alu_flags,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [4:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_last_grant;  // requester granted most recently
  logic             r_owner;       // requester whose operation is in flight
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_ctl;
  logic [WIDTH-1:0] r_rsp_result;
  logic [4:0]       r_rsp_flags;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic             w_rsp_done;

  // Grant is purely combinational in IDLE. On contention, the requester
  // that was not granted last wins. Grant already implies valid, so it
  // doubles as the accept qualifier.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_accept   = w_gnt0 | w_gnt1;
  // Only the owner's ready matters, and only in RESP.
  assign w_rsp_done = (r_state == ST_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
      ST_EXEC:                 w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath. last_grant resets to 1 so that requester 0 wins the first
  // contention. A request withdrawn before acceptance never reaches the
  // accept branch, so it leaves last_grant untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctl    <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a      <= w_gnt1 ? req1_a  : req0_a;
        r_alu_b      <= w_gnt1 ? req1_b  : req0_b;
        r_alu_ctl    <= w_gnt1 ? req1_op : req0_op;
        r_owner      <= w_gnt1;
        r_last_grant <= w_gnt1;
      end
      // The ALU has had a full cycle on stable operands; sample on EXEC exit.
      if (r_state == ST_EXEC) begin
        r_rsp_result <= alu_result;
        r_rsp_flags  <= alu_flags;
      end
    end
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_ctl;
  assign rsp0_valid  = (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid  = (r_state == ST_RESP) &&  r_owner;
  assign rsp_result  = r_rsp_result;
  assign rsp_flags   = r_rsp_flags;
  assign busy        = (r_state != ST_IDLE);

  // Structural invariants of the arbiter
  a_one_ready : assert property (@(posedge clk) disable iff (reset)
    !(req0_ready && req1_ready));
  a_rsp_hold  : assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_RESP && !w_rsp_done) |=> ($stable(r_rsp_result) && $stable(r_rsp_flags)));

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_control;
  logic [4:0]   alu_flags;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic [4:0]   rsp_flags;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Stand-in ALU. Returns {C,L,F,Z,N, result}.
  // Ops: 1000 ADD, 0001 SUB, 0010 CMP (result 0, flags of a-b),
  // 0000 AND, 0011 OR, anything else XOR.
  function automatic logic [W+4:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] op);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, l, f, z, n;
    c = 1'b0; l = 1'b0; f = 1'b0; s = '0;
    case (op)
      4'b1000: begin
        s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
        f = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0001, 4'b0010: begin
        s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W]; l = (a < b);
        f = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0000: r = a & b;
      4'b0011: r = a | b;
      default: r = a ^ b;
    endcase
    z = (r == '0);
    n = r[W-1];
    if (op == 4'b0010) r = '0;
    return {c, l, f, z, n, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_control);

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    next_cyc(); next_cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #2;  // before any clock edge: async reset alone must set outputs
    n_cmp++;
    if ({alu_a, alu_b, alu_control, rsp_result, rsp_flags} !== '0) begin
      n_fail++; $display("FAIL reset_data got a=%h b=%h op=%h res=%h fl=%h exp all 0",
                         alu_a, alu_b, alu_control, rsp_result, rsp_flags);
    end
    n_cmp++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got v0v1busy=%b exp 000", {rsp0_valid, rsp1_valid, busy});
    end
    next_cyc(); next_cyc();
    reset = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1; req0_a = 16'h0003; req0_b = 16'h0001; req0_op = 4'b1000;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready});
    end
    next_cyc();
    req0_valid = 0;
    n_cmp++;
    if ({alu_a, alu_b, alu_control, rsp0_valid, busy} !== {16'h0003, 16'h0001, 4'b1000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL single_exec got a=%h b=%h op=%b v0=%b busy=%b exp 0003 0001 1000 0 1",
                         alu_a, alu_b, alu_control, rsp0_valid, busy);
    end
    next_cyc();
    n_cmp++;
    if ({rsp0_valid, rsp1_valid, rsp_result} !== {2'b10, 16'h0004}) begin
      n_fail++; $display("FAIL single_rsp got v=%b%b res=%h exp 10 0004", rsp0_valid, rsp1_valid, rsp_result);
    end
    rsp0_ready = 1;
    next_cyc();
    rsp0_ready = 0;
    n_cmp++;
    if ({busy, rsp0_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_done got busy=%b v0=%b exp 0 0", busy, rsp0_valid);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1; req0_a = 3; req0_b = 1; req0_op = 4'b0001;
    req1_valid = 1; req1_a = 2; req1_b = 3; req1_op = 4'b0010;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL cont_first got %b exp 10", {req0_ready, req1_ready});
    end
    next_cyc();
    req0_valid = 0;
    next_cyc();
    n_cmp++;
    if ({rsp0_valid, rsp_result} !== {1'b1, 16'h0002}) begin
      n_fail++; $display("FAIL cont_rsp0 got v0=%b res=%h exp 1 0002", rsp0_valid, rsp_result);
    end
    rsp0_ready = 1;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL cont_resp_noaccept got req1_ready=%b exp 0", req1_ready);
    end
    next_cyc();
    rsp0_ready = 0;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL cont_second got req1_ready=%b exp 1", req1_ready);
    end
    next_cyc();
    req1_valid = 0;
    next_cyc();
    n_cmp++;
    if ({rsp1_valid, rsp0_valid, rsp_flags[3]} !== 3'b101) begin
      n_fail++; $display("FAIL cont_cmp got v1=%b v0=%b L=%b exp 1 0 1", rsp1_valid, rsp0_valid, rsp_flags[3]);
    end
    rsp1_ready = 1;
    next_cyc();
    rsp1_ready = 0;
  endtask

  task automatic test_fairness();
    int g[$];
    int c0, c1;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    for (int cyc = 0; cyc < 80 && g.size() < 8; cyc++) begin
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 4'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 4'($urandom);
      #1;
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      next_cyc();
    end
    req0_valid = 0; req1_valid = 0;
    n_cmp++;
    if (g.size() != 8) begin
      n_fail++; $display("FAIL fair_count got %0d grants exp 8", g.size());
    end
    c0 = 0; c1 = 0;
    foreach (g[i]) begin
      n_cmp++;
      if (g[i] != (i % 2)) begin
        n_fail++; $display("FAIL fair_order grant[%0d] got %0d exp %0d", i, g[i], i % 2);
      end
      if (g[i] == 0) c0++; else c1++;
    end
    n_cmp++;
    if (c0 != 4 || c1 != 4) begin
      n_fail++; $display("FAIL fair_split got %0d/%0d exp 4/4", c0, c1);
    end
    next_cyc(); next_cyc(); next_cyc();
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_backpressure();
    logic [W+4:0] e;
    @(negedge clk);
    req1_valid = 1; req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 4'b1000;
    rsp1_ready = 0; rsp0_ready = 1;  // non-owner ready must be ignored
    e = alu_fn(req1_a, req1_b, req1_op);
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept got req1_ready=%b exp 1", req1_ready);
    end
    next_cyc();
    req1_valid = 0;
    req0_valid = 1; req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 4'b0011;
    next_cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({rsp1_valid, rsp0_valid, req0_ready, rsp_flags, rsp_result} !== {3'b100, e}) begin
        n_fail++; $display("FAIL bp_hold k=%0d got v1=%b v0=%b r0=%b fl=%h res=%h exp 1 0 0 %h %h",
                           k, rsp1_valid, rsp0_valid, req0_ready, rsp_flags, rsp_result, e[W+4:W], e[W-1:0]);
      end
      if (k < 4) next_cyc();
    end
    rsp1_ready = 1;
    next_cyc();
    #1;
    n_cmp++;
    if ({busy, rsp1_valid, req0_ready} !== 3'b001) begin
      n_fail++; $display("FAIL bp_release got busy=%b v1=%b r0=%b exp 0 0 1", busy, rsp1_valid, req0_ready);
    end
    req0_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req0_valid = 1; req0_a = 16'h1234 | 16'($urandom); req0_b = 16'($urandom); req0_op = 4'b1000;
    next_cyc();
    req0_valid = 0;
    rsp0_ready = 1;
    #2;
    reset = 1;
    #1;  // still well before the next rising edge
    n_cmp++;
    if ({busy, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_control, rsp_result, rsp_flags} !== '0) begin
      n_fail++; $display("FAIL mid_reset_async got busy=%b v=%b%b a=%h b=%h op=%h res=%h fl=%h exp all 0",
                         busy, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_control, rsp_result, rsp_flags);
    end
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      n_cmp++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        n_fail++; $display("FAIL mid_reset_norsp k=%0d got v=%b%b busy=%b exp 000", k, rsp0_valid, rsp1_valid, busy);
      end
    end
    rsp0_ready = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL mid_reset_rr got %b exp 10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  // Randomised traffic against a transaction-level model: one operation in
  // flight, one EXEC cycle, then a held response until the owner takes it.
  task automatic test_random();
    bit           mb, mown, mlast, g0, g1, ev0, ev1;
    int           age, served;
    logic [W+4:0] mexp;
    do_reset();
    mb = 0; mlast = 1; age = 0; mown = 0; served = 0; mexp = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 4'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 4'($urandom);
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      #1;
      g0 = !mb && req0_valid && (!req1_valid || mlast);
      g1 = !mb && req1_valid && (!req0_valid || !mlast);
      ev0 = mb && age >= 1 && !mown;
      ev1 = mb && age >= 1 &&  mown;
      n_cmp++;
      if ({req0_ready, req1_ready, busy} !== {g0, g1, mb}) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d got r=%b%b busy=%b exp r=%b%b busy=%b",
                           cyc, req0_ready, req1_ready, busy, g0, g1, mb);
      end
      n_cmp++;
      if ({rsp0_valid, rsp1_valid} !== {ev0, ev1}) begin
        n_fail++; $display("FAIL rnd_rspv cyc=%0d got %b%b exp %b%b", cyc, rsp0_valid, rsp1_valid, ev0, ev1);
      end
      if (ev0 || ev1) begin
        n_cmp++;
        if ({rsp_flags, rsp_result} !== mexp) begin
          n_fail++; $display("FAIL rnd_data cyc=%0d got fl=%h res=%h exp fl=%h res=%h",
                             cyc, rsp_flags, rsp_result, mexp[W+4:W], mexp[W-1:0]);
        end
      end
      if (g0 || g1) begin
        mb = 1; age = 0; mown = g1; mlast = g1; served++;
        mexp = g1 ? alu_fn(req1_a, req1_b, req1_op) : alu_fn(req0_a, req0_b, req0_op);
      end else if (mb) begin
        if (age == 0) age = 1;
        else if (mown ? rsp1_ready : rsp0_ready) mb = 0;
      end
    end
    n_cmp++;
    if (served < 40) begin
      n_fail++; $display("FAIL rnd_served got %0d ops exp at least 40", served);
    end
    @(negedge clk);
    idle_inputs();
    rsp0_ready = 1; rsp1_ready = 1;
    next_cyc(); next_cyc(); next_cyc();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid / req1_valid  input  1  requester N presents an ALU operation.
REQ-005 Port: req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands from requester N.
REQ-006 Port: req0_op / req1_op  input  4  aluControl code from requester N, passed through unmodified.
REQ-007 Port: req0_ready / req1_ready  output  1  request accepted this cycle when valid and ready are both high.
REQ-008 Port: alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-009 Port: alu_control  output  4  operation code driven to the shared ALU.
REQ-010 Port: alu_result  input  WIDTH  combinational result from the ALU.
REQ-011 Port: alu_flags  input  5  ALU flags packed {C,L,F,Z,N}, bit 4 = C, bit 0 = N.
REQ-012 Port: rsp0_valid / rsp1_valid  output  1  response for requester N is held.
REQ-013 Port: rsp0_ready / rsp1_ready  input  1  requester N consumes its response.
REQ-014 Port: rsp_result  output  WIDTH  captured ALU result.
REQ-015 Port: rsp_flags  output  5  captured flags, same packing as alu_flags.
REQ-016 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM has exactly three states: IDLE, EXEC and RESP.
REQ-018 In IDLE, the grant is combinational:
- only one valid: that requester is granted;
- both valid: the requester not granted last is granted (round-robin);
- none valid: no grant.
REQ-019 reqN_ready is high only in IDLE and only for the granted N; both ready signals are never high together.
REQ-020 On an accepting edge (IDLE, valid and ready):
- a, b and op are registered into alu_a, alu_b and alu_control;
- the owner and last_grant are set to N;
- state moves to EXEC.
REQ-021 alu_a, alu_b and alu_control change only on an accepting edge and are otherwise held stable.
REQ-022 On the EXEC-exit edge, alu_result and alu_flags are registered into rsp_result and rsp_flags, and state moves to RESP.
REQ-023 In RESP:
- rspN_valid is high for the owner only;
- rsp_result and rsp_flags are held stable;
- the block stays in RESP until rspN_ready is high.
REQ-024 On the edge where the owner's rspN_valid and rspN_ready are both high, state moves to IDLE; a new accept cannot happen before the following cycle.
REQ-025 Timing: latency is accept edge to rspN_valid high = 2 cycles; peak throughput is one operation per 3 cycles.
REQ-026 rspN_ready is ignored outside RESP and for the non-owner.
REQ-027 A requester that drops valid before acceptance is not served and leaves last_grant unchanged.
REQ-028 The block does not interpret op codes or flags; CMP results appear only in rsp_flags.

Reset
REQ-029 While reset is high, independent of clk:
- state = IDLE and last_grant = 1, so req0 wins the first contention;
- owner = 0;
- alu_a, alu_b, alu_control, rsp_result and rsp_flags = 0;
- rsp0_valid, rsp1_valid and busy = 0.
REQ-030 Reset asserted during EXEC or RESP discards the in-flight operation, and no response is ever delivered for it.

Verification
REQ-031 Single request: req0 a=0x0003, b=0x0001, op=1000 -> req0_ready high in the same cycle; rsp0_valid high 2 cycles after accept; rsp_result=0x0004.
REQ-032 Contention after reset: req0 SUB (op 0001) with 3,1 and req1 CMP (op 0010) with 2,3 both valid ->
- req0 served first with rsp_result=0x0002;
- req1 then accepted, and rsp_flags bit 3 (L)=1.
REQ-033 Fairness: both requesters held valid continuously for 8 operations -> grants alternate 0,1,0,1,...; each requester gets exactly 4.
REQ-034 Backpressure: rsp1_ready held low 5 cycles in RESP -> rsp1_valid stays high, rsp_result stays stable, req0_ready stays 0; IDLE is reached the edge after rsp1_ready rises.
REQ-035 Reset mid-operation: reset pulsed while in EXEC ->
- outputs zero immediately, without waiting for a clock edge;
- no rspN_valid pulse for the discarded operation;
- the next contention is won by req0.
